// File: rtl/toccata_play_ctrl.sv
// Toccata playback sequencer: sample-rate tick, FIFO byte drain, 16-bit L/R assembly,
// refill IRQ and underrun flag.
module toccata_play_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  mode_16bit,
  input  logic                  mode_stereo,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic                  fifo_empty,
  input  logic                  fifo_half_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  irq_clr,
  output logic [15:0]           sample_l,
  output logic [15:0]           sample_r,
  output logic                  sample_valid,
  output logic                  irq,
  output logic                  underrun,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q;
  logic                  tick;
  logic                  m16_q, mst_q;
  logic [1:0]            idx_q, last_q;
  logic [DATA_WIDTH-1:0] byte_q [4];
  logic [DATA_WIDTH-1:0] byte_full [4];
  logic [15:0]           l_next, r_next;
  logic                  frame_start, cap, frame_done, underrun_set;

  assign tick         = enable && (cnt_q == '0);
  assign frame_start  = enable && (state_q == S_WAIT) && tick;
  assign cap          = enable && (state_q == S_CAP);
  assign frame_done   = cap && (idx_q == last_q);
  assign underrun_set = enable && (state_q == S_RD) && fifo_empty;

  assign busy         = (state_q != S_IDLE);
  assign sample_valid = (state_q == S_OUT);
  assign state_dbg    = state_q;

  always_ff @(posedge clk) begin
    if (rst)                 cnt_q <= '0;
    else if (!enable)        cnt_q <= '0;
    else if (cnt_q == '0)    cnt_q <= rate_div;
    else                     cnt_q <= cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Disabling overrides every state so no read can be issued once enable drops.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: if (tick) state_d = S_RD;
        S_RD: begin
          if (fifo_empty) begin
            state_d = S_WAIT;
          end else begin
            fifo_rd_en = 1'b1;
            state_d    = S_CAP;
          end
        end
        S_CAP:   state_d = (idx_q == last_q) ? S_OUT : S_RD;
        S_OUT:   state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame bytes including the one arriving this cycle, so samples load as CAP ends.
  always_comb begin
    for (int i = 0; i < 4; i++) byte_full[i] = byte_q[i];
    byte_full[idx_q] = fifo_data;
    if (m16_q) begin
      l_next = {byte_full[0], byte_full[1]};
      r_next = mst_q ? {byte_full[2], byte_full[3]} : l_next;
    end else begin
      l_next = {byte_full[0], 8'h00};
      r_next = mst_q ? {byte_full[1], 8'h00} : l_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m16_q    <= 1'b0;
      mst_q    <= 1'b0;
      idx_q    <= 2'd0;
      last_q   <= 2'd0;
      for (int i = 0; i < 4; i++) byte_q[i] <= '0;
      sample_l <= '0;
      sample_r <= '0;
      irq      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (frame_start) begin
        m16_q  <= mode_16bit;
        mst_q  <= mode_stereo;
        idx_q  <= 2'd0;
        // Index of the final byte: 0, 1 or 3 for 1, 2 or 4 bytes per frame.
        last_q <= {mode_16bit & mode_stereo, mode_16bit | mode_stereo};
      end
      if (cap) begin
        byte_q[idx_q] <= fifo_data;
        idx_q         <= idx_q + 2'd1;
      end
      if (frame_done) begin
        sample_l <= l_next;
        sample_r <= r_next;
      end
      if (enable && fifo_half_empty) irq <= 1'b1;
      else if (irq_clr)              irq <= 1'b0;
      if (underrun_set)              underrun <= 1'b1;
      else if (irq_clr)              underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toccata_play_ctrl.sv
// Directed bench for toccata_play_ctrl with a small byte-FIFO model feeding the DUT.
module tb_toccata_play_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        mode_16bit = 1'b0;
  logic        mode_stereo = 1'b0;
  logic [15:0] rate_div = 16'd0;
  logic        fifo_empty;
  logic        fifo_half_empty = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        irq_clr = 1'b0;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid, irq, underrun, busy;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: initial block pushes, the clocked block pops on fifo_rd_en.
  logic [7:0] mem [16];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  int rd_cnt = 0;
  int sv_cnt = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  toccata_play_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode_16bit(mode_16bit),
    .mode_stereo(mode_stereo), .rate_div(rate_div), .fifo_empty(fifo_empty),
    .fifo_half_empty(fifo_half_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
    .irq_clr(irq_clr), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .irq(irq), .underrun(underrun), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 8'd1;
      rd_cnt    = rd_cnt + 1;
    end
    if (sample_valid) sv_cnt = sv_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // which: 0 = fifo_rd_en, 1 = sample_valid; n = cycles waited, -1 on timeout
  task automatic wait_for(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((which == 0 && fifo_rd_en) || (which == 1 && sample_valid)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  int n, n2, rd_base, sv_base;

  initial begin
    do_reset();
    check("rst_sample_l", sample_l, 16'h0);
    check("rst_sample_r", sample_r, 16'h0);
    check("rst_sample_valid", sample_valid, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);

    // Mono 8-bit, rate_div=3: reads every 4 cycles.
    rate_div = 16'd3; mode_16bit = 1'b0; mode_stereo = 1'b0;
    push(8'h11); push(8'h22);
    rd_base = rd_cnt;
    enable = 1'b1;
    wait_for(0, 20, n);
    check("m8_first_rd_latency", n, 5);
    wait_for(1, 10, n);
    check("m8_rd_to_valid", n, 2);
    check("m8_l0", sample_l, 16'h1100);
    check("m8_r0", sample_r, 16'h1100);
    wait_for(0, 10, n2);
    check("m8_rd_period", n + n2, 4);
    wait_for(1, 10, n);
    check("m8_l1", sample_l, 16'h2200);
    check("m8_r1", sample_r, 16'h2200);
    enable = 1'b0;
    step();
    check("m8_rd_count", rd_cnt - rd_base, 2);
    check("m8_busy_off", busy, 1'b0);

    // Stereo 8-bit with one byte: underrun on second RD, samples untouched.
    mode_stereo = 1'b1;
    push(8'hAB);
    rd_base = rd_cnt; sv_base = sv_cnt;
    enable = 1'b1;
    wait_for(0, 20, n);
    check("s8u_rd_seen", n, 5);
    step();
    check("s8u_cap_no_rd", fifo_rd_en, 1'b0);
    step();
    check("s8u_rd_empty_no_rd", fifo_rd_en, 1'b0);
    check("s8u_underrun_pre", underrun, 1'b0);
    step();
    check("s8u_underrun_set", underrun, 1'b1);
    enable = 1'b0;
    step(); step(); step();
    check("s8u_sv_none", sv_cnt - sv_base, 0);
    check("s8u_rd_count", rd_cnt - rd_base, 1);
    check("s8u_l_hold", sample_l, 16'h2200);
    check("s8u_r_hold", sample_r, 16'h2200);
    check("s8u_underrun_hold", underrun, 1'b1);

    // irq: set beats clear, then a lone clear drops irq and underrun.
    fifo_half_empty = 1'b1;
    step();
    fifo_half_empty = 1'b0;
    check("irq_no_set_disabled", irq, 1'b0);
    enable = 1'b1; fifo_half_empty = 1'b1; irq_clr = 1'b1;
    step();
    fifo_half_empty = 1'b0; irq_clr = 1'b0;
    check("irq_set_wins", irq, 1'b1);
    enable = 1'b0;
    step();
    check("irq_hold_disabled", irq, 1'b1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq_cleared", irq, 1'b0);
    check("underrun_cleared", underrun, 1'b0);

    // Stereo 16-bit frame: 4 reads, valid 8 cycles after first read (9 after tick).
    do_reset();
    rate_div = 16'd15; mode_16bit = 1'b1; mode_stereo = 1'b1;
    push(8'h12); push(8'h34); push(8'h56); push(8'h78);
    rd_base = rd_cnt; sv_base = sv_cnt;
    enable = 1'b1;
    wait_for(0, 40, n);
    check("s16_first_rd_latency", n, 17);
    wait_for(1, 20, n);
    check("s16_rd_to_valid", n, 8);
    check("s16_l", sample_l, 16'h1234);
    check("s16_r", sample_r, 16'h5678);
    check("s16_rd_count", rd_cnt - rd_base, 4);
    enable = 1'b0;
    step();

    // Drop enable during CAP of a 16-bit stereo frame.
    do_reset();
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    rd_base = rd_cnt; sv_base = sv_cnt;
    enable = 1'b1;
    wait_for(0, 40, n);
    step();
    check("abort_busy_in_cap", busy, 1'b1);
    enable = 1'b0;
    step();
    check("abort_busy_next", busy, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("abort_rd_count", rd_cnt - rd_base, 1);
    check("abort_sv_none", sv_cnt - sv_base, 0);
    check("abort_l_hold", sample_l, 16'h0);

    // rate_div=2 with 9-cycle frames: overlapping ticks dropped, no underrun.
    do_reset();
    rate_div = 16'd2;
    for (int i = 1; i <= 12; i++) push(8'(i));
    rd_base = rd_cnt;
    enable = 1'b1;
    wait_for(1, 40, n);
    check("fast_f0_l", sample_l, 16'h0102);
    check("fast_f0_r", sample_r, 16'h0304);
    wait_for(1, 40, n);
    check("fast_gap_ok", (n >= 9) && (n % 3 == 0), 1);
    check("fast_f1_l", sample_l, 16'h0506);
    check("fast_f1_r", sample_r, 16'h0708);
    wait_for(1, 40, n);
    check("fast_f2_l", sample_l, 16'h090A);
    check("fast_f2_r", sample_r, 16'h0B0C);
    check("fast_underrun", underrun, 1'b0);
    check("fast_rd_count", rd_cnt - rd_base, 12);
    enable = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
